// File: rtl/fc_pkg.sv
// Shared types and default sizes for the fully-connected output stage and its argmax classifier.
package fc_pkg;

  localparam int unsigned FC_WORD_SIZE     = 16;
  localparam int unsigned FC_OP_LAYER_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

  typedef logic signed [FC_WORD_SIZE-1:0] fc_word_t;

endpackage

// File: rtl/fc_argmax.sv
// Sequential argmax over one frame of FC-layer scores: capture, scan one score per cycle with a
// signed strict compare (lowest index wins ties), then hold the result until it is accepted.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = FC_WORD_SIZE,
  parameter int unsigned OP_LAYER_SIZE = FC_OP_LAYER_SIZE,
  localparam int unsigned IDX_W        = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] Z [OP_LAYER_SIZE],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     class_idx,
  output logic [WORD_SIZE-1:0] class_score
);

  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(OP_LAYER_SIZE - 1);
  localparam logic [IDX_W-1:0] FirstCnt = (OP_LAYER_SIZE > 1) ? IDX_W'(1) : '0;

  argmax_state_t        r_state;
  argmax_state_t        w_state_next;
  logic [WORD_SIZE-1:0] r_buf [OP_LAYER_SIZE];
  logic [WORD_SIZE-1:0] r_best_score;
  logic [IDX_W-1:0]     r_best_idx;
  logic [IDX_W-1:0]     r_cnt;

  logic                 w_accept;
  logic                 w_scan;
  logic                 w_last;
  logic [WORD_SIZE-1:0] w_cand;
  logic                 w_better;

  assign w_last   = (r_cnt == LastIdx);
  assign w_cand   = r_buf[r_cnt];
  assign w_better = $signed(w_cand) > $signed(r_best_score);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_scan       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = (OP_LAYER_SIZE == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        w_scan = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Buffer decouples Z so the producer may move on right after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf        <= '{default: '0};
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_cnt        <= '0;
    end else if (w_accept) begin
      r_buf        <= Z;
      r_best_score <= Z[0];
      r_best_idx   <= '0;
      r_cnt        <= FirstCnt;
    end else if (w_scan) begin
      if (w_better) begin
        r_best_score <= w_cand;
        r_best_idx   <= r_cnt;
      end
      if (!w_last) begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign class_idx   = r_best_idx;
  assign class_score = r_best_score;

endmodule
